// File: rtl/ex_mem_skid_pkg.sv
// Shared types for the EX->MEM skid stage.
// Optional stall counter is enabled with EXMEM_STALL_CNT_EN.
package ex_mem_skid_pkg;

  localparam int EXMEM_XLEN   = 32;
  localparam int EXMEM_REG_AW = 5;
  localparam int EXMEM_INST_W = 32;

  localparam logic [1:0] MEMCNF_NONE = 2'd0;
  localparam logic [1:0] MEMCNF_B    = 2'd1;
  localparam logic [1:0] MEMCNF_H    = 2'd2;
  localparam logic [1:0] MEMCNF_W    = 2'd3;

  localparam logic MEMWR_LOAD  = 1'b0;
  localparam logic MEMWR_STORE = 1'b1;

  typedef struct packed {
    logic [EXMEM_INST_W-1:0] inst;
    logic [EXMEM_REG_AW-1:0] wd;
    logic                    wreg;
    logic [EXMEM_XLEN-1:0]   wdata;
    logic [EXMEM_XLEN-1:0]   memaddr;
    logic                    memwr;
    logic [1:0]              memcnf;
    logic                    memsigned;
  } exmem_payload_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

endpackage

// File: rtl/ex_mem_skid_buf.sv
// Generic 2-entry skid buffer; M drives the output, S absorbs
// the beat that arrives while ready is still registered high.
module skid_buf
  import ex_mem_skid_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  state_t       state_q;
  logic         rdy_q;
  logic [W-1:0] m_q;
  logic [W-1:0] s_q;
  logic         acc;
  logic         drn;

  assign acc         = in_valid_i & rdy_q;
  assign drn         = out_valid_o & out_ready_i;
  assign in_ready_o  = rdy_q;
  assign out_valid_o = (state_q != EMPTY);
  assign out_data_o  = m_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      rdy_q   <= 1'b1;
      m_q     <= '0;
      s_q     <= '0;
    end else if (flush) begin
      state_q <= EMPTY;
      rdy_q   <= 1'b1;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (acc) begin
            m_q     <= in_data_i;
            state_q <= ONE;
          end
        end
        ONE: begin
          if (acc && drn) begin
            m_q <= in_data_i;
          end else if (acc) begin
            s_q     <= in_data_i;
            state_q <= TWO;
            rdy_q   <= 1'b0;
          end else if (drn) begin
            state_q <= EMPTY;
          end
        end
        TWO: begin
          if (drn) begin
            m_q     <= s_q;
            state_q <= ONE;
            rdy_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= EMPTY;
          rdy_q   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/ex_mem_skid.sv
// EX->MEM stage register with valid/ready and a 2-entry skid.
// Define EXMEM_STALL_CNT_EN to add the saturating stall_cnt output.
module ex_mem_skid
  import ex_mem_skid_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] ex_wd,
  input  logic              ex_wreg,
  input  logic [XLEN-1:0]   ex_wdata,
  input  logic [XLEN-1:0]   ex_memaddr,
  input  logic              ex_memwr,
  input  logic [1:0]        ex_memcnf,
  input  logic              ex_memsigned,
  input  logic [INST_W-1:0] ex_inst,
`ifdef EXMEM_STALL_CNT_EN
  output logic [31:0]       stall_cnt,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [REG_AW-1:0] mem_wd,
  output logic              mem_wreg,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN-1:0]   mem_memaddr,
  output logic              mem_memwr,
  output logic [1:0]        mem_memcnf,
  output logic              mem_memsigned,
  output logic [INST_W-1:0] mem_inst
);

  // Same layout as exmem_payload_t, sized by this instance's parameters.
  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [REG_AW-1:0] wd;
    logic              wreg;
    logic [XLEN-1:0]   wdata;
    logic [XLEN-1:0]   memaddr;
    logic              memwr;
    logic [1:0]        memcnf;
    logic              memsigned;
  } payload_t;

  payload_t in_p;
  payload_t m_p;

  assign in_p.inst      = ex_inst;
  assign in_p.wd        = ex_wd;
  assign in_p.wreg      = ex_wreg;
  assign in_p.wdata     = ex_wdata;
  assign in_p.memaddr   = ex_memaddr;
  assign in_p.memwr     = ex_memwr;
  assign in_p.memcnf    = ex_memcnf;
  assign in_p.memsigned = ex_memsigned;

  skid_buf #(
    .W($bits(payload_t))
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_p),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (m_p)
  );

  // A bubble must look like a NOP to MEM.
  assign mem_wd        = out_valid ? m_p.wd : '0;
  assign mem_wreg      = out_valid & m_p.wreg;
  assign mem_memcnf    = out_valid ? m_p.memcnf : MEMCNF_NONE;
  assign mem_wdata     = m_p.wdata;
  assign mem_memaddr   = m_p.memaddr;
  assign mem_memwr     = m_p.memwr;
  assign mem_memsigned = m_p.memsigned;
  assign mem_inst      = m_p.inst;

`ifdef EXMEM_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready && stall_q != '1) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_ex_mem_skid.sv
// Scoreboard bench for ex_mem_skid: directed beats, negedge monitor.
// Build with EXMEM_STALL_CNT_EN to also exercise stall_cnt.
module tb_ex_mem_skid;
  import ex_mem_skid_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic [4:0]  ex_wd, mem_wd;
  logic        ex_wreg, mem_wreg;
  logic [31:0] ex_wdata, mem_wdata;
  logic [31:0] ex_memaddr, mem_memaddr;
  logic        ex_memwr, mem_memwr;
  logic [1:0]  ex_memcnf, mem_memcnf;
  logic        ex_memsigned, mem_memsigned;
  logic [31:0] ex_inst, mem_inst;
  logic        out_valid, out_ready;
`ifdef EXMEM_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int n_pass = 0;
  int n_total = 0;
  exmem_payload_t sb[$];

  always #5 clk = ~clk;

  ex_mem_skid dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .ex_wd        (ex_wd),
    .ex_wreg      (ex_wreg),
    .ex_wdata     (ex_wdata),
    .ex_memaddr   (ex_memaddr),
    .ex_memwr     (ex_memwr),
    .ex_memcnf    (ex_memcnf),
    .ex_memsigned (ex_memsigned),
    .ex_inst      (ex_inst),
`ifdef EXMEM_STALL_CNT_EN
    .stall_cnt    (stall_cnt),
`endif
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .mem_wd       (mem_wd),
    .mem_wreg     (mem_wreg),
    .mem_wdata    (mem_wdata),
    .mem_memaddr  (mem_memaddr),
    .mem_memwr    (mem_memwr),
    .mem_memcnf   (mem_memcnf),
    .mem_memsigned(mem_memsigned),
    .mem_inst     (mem_inst)
  );

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  function automatic exmem_payload_t mk(input logic [31:0] d,
                                        input logic [1:0] cnf,
                                        input logic wr,
                                        input logic [31:0] a);
    exmem_payload_t p;
    p.inst      = 32'h0000_0013 ^ (d << 8);
    p.wd        = d[4:0] | 5'd1;
    p.wreg      = 1'b1;
    p.wdata     = d;
    p.memaddr   = a;
    p.memwr     = wr;
    p.memcnf    = cnf;
    p.memsigned = d[0];
    return p;
  endfunction

  task automatic drive(input exmem_payload_t p);
    ex_inst      = p.inst;
    ex_wd        = p.wd;
    ex_wreg      = p.wreg;
    ex_wdata     = p.wdata;
    ex_memaddr   = p.memaddr;
    ex_memwr     = p.memwr;
    ex_memcnf    = p.memcnf;
    ex_memsigned = p.memsigned;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every beat MEM takes must be the oldest expected one.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      exmem_payload_t act, exp;
      act = {mem_inst, mem_wd, mem_wreg, mem_wdata, mem_memaddr,
             mem_memwr, mem_memcnf, mem_memsigned};
      if (sb.size() == 0) begin
        chk("unexpected_beat", 128'(act), 128'(0));
      end else begin
        exp = sb.pop_front();
        chk("beat", 128'(act), 128'(exp));
      end
    end
  end

  initial begin
    exmem_payload_t p;
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
    drive(mk(32'hDEAD, MEMCNF_W, MEMWR_STORE, 32'h40));

    // Reset with in_valid high
    tick(); tick();
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_wdata", 128'(mem_wdata), 128'(0));
    chk("rst_addr", 128'(mem_memaddr), 128'(0));
    chk("rst_inst", 128'(mem_inst), 128'(0));
    chk("rst_misc", 128'({mem_wd, mem_wreg, mem_memwr, mem_memcnf,
                          mem_memsigned}), 128'(0));
    rst = 1'b0; in_valid = 1'b0;
    tick();
    chk("post_rst_empty", 128'(out_valid), 128'(0));

    // Streaming
    in_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      p = mk(32'(i), MEMCNF_NONE, MEMWR_LOAD, 32'h0);
      drive(p); sb.push_back(p);
      tick();
      chk("stream_valid", 128'(out_valid), 128'(1));
      chk("stream_data", 128'(mem_wdata), 128'(i));
    end
    in_valid = 1'b0;
    tick();
    chk("stream_end", 128'(out_valid), 128'(0));

    // Backpressure into TWO
    out_ready = 1'b0; in_valid = 1'b1;
    p = mk(32'hA, MEMCNF_W, MEMWR_LOAD, 32'h20);
    drive(p); sb.push_back(p);
    tick();
    chk("bp_ready_one", 128'(in_ready), 128'(1));
    p = mk(32'hB, MEMCNF_H, MEMWR_LOAD, 32'h24);
    drive(p); sb.push_back(p);
    tick();
    chk("bp_ready_two", 128'(in_ready), 128'(0));
    chk("bp_data_a", 128'(mem_wdata), 128'(32'hA));
    in_valid = 1'b0;
    drive(mk(32'h77, MEMCNF_B, MEMWR_STORE, 32'h99));
    tick();
    chk("bp_hold_a", 128'(mem_wdata), 128'(32'hA));
    chk("bp_hold_ready", 128'(in_ready), 128'(0));
    out_ready = 1'b1;
    tick();
    chk("bp_ready_back", 128'(in_ready), 128'(1));
    chk("bp_data_b", 128'(mem_wdata), 128'(32'hB));
    tick();
    chk("bp_empty", 128'(out_valid), 128'(0));

    // Flush with two entries held; the 0xC beat must be dropped
    out_ready = 1'b0; in_valid = 1'b1;
    drive(mk(32'h21, MEMCNF_W, MEMWR_LOAD, 32'h30));
    tick();
    drive(mk(32'h22, MEMCNF_W, MEMWR_LOAD, 32'h34));
    tick();
    chk("fl_two", 128'(in_ready), 128'(0));
    flush = 1'b1;
    drive(mk(32'hC, MEMCNF_W, MEMWR_STORE, 32'h38));
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid", 128'(out_valid), 128'(0));
    chk("fl_wreg", 128'(mem_wreg), 128'(0));
    chk("fl_cnf", 128'(mem_memcnf), 128'(0));
    chk("fl_ready", 128'(in_ready), 128'(1));
    out_ready = 1'b1;
    tick(); tick();
    chk("fl_no_c", 128'(out_valid), 128'(0));

    // Flush while draining: the drain completes, the new beat is lost
    in_valid = 1'b1;
    p = mk(32'hE, MEMCNF_B, MEMWR_LOAD, 32'h44);
    drive(p); sb.push_back(p);
    tick();
    chk("fd_valid", 128'(out_valid), 128'(1));
    flush = 1'b1;
    drive(mk(32'hD, MEMCNF_W, MEMWR_STORE, 32'h48));
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fd_empty", 128'(out_valid), 128'(0));
    tick();
    chk("fd_no_d", 128'(out_valid), 128'(0));

    // Store drains, then the bubble reads as a NOP
    in_valid = 1'b1;
    p = mk(32'h55, MEMCNF_W, MEMWR_STORE, 32'h100);
    drive(p); sb.push_back(p);
    tick();
    in_valid = 1'b0;
    chk("st_cnf", 128'(mem_memcnf), 128'(3));
    chk("st_wr", 128'(mem_memwr), 128'(1));
    tick();
    chk("nop_valid", 128'(out_valid), 128'(0));
    chk("nop_cnf", 128'(mem_memcnf), 128'(0));
    chk("nop_wreg", 128'(mem_wreg), 128'(0));
    chk("nop_wd", 128'(mem_wd), 128'(0));
    chk("nop_addr_kept", 128'(mem_memaddr), 128'(32'h100));

`ifdef EXMEM_STALL_CNT_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("cnt_rst", 128'(stall_cnt), 128'(0));
    out_ready = 1'b0; in_valid = 1'b1;
    p = mk(32'hF, MEMCNF_W, MEMWR_LOAD, 32'h60);
    drive(p); sb.push_back(p);
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    chk("cnt_five", 128'(stall_cnt), 128'(5));
    out_ready = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("cnt_flush", 128'(stall_cnt), 128'(5));
    chk("cnt_fl_empty", 128'(out_valid), 128'(0));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("cnt_clear", 128'(stall_cnt), 128'(0));
`endif

    tick();
    chk("sb_drained", 128'(sb.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ex_mem_skid.md
Name: ex_mem_skid

Overview:
- Parametrised EX->MEM pipeline stage register. Successor to the single-register stall-hold stage.
- Replaces the global stall input with a valid/ready handshake on both sides and adds a 2-entry skid buffer, so in_ready is a pure register output with no combinational ready path from MEM back to EX.
- Adds a synchronous flush for branch mispredict and exceptions.
- Sits between the EX stage and the MEM stage / memory controller.

Parameters:
- XLEN, 32, width of wdata and memaddr.
- REG_AW, 5, width of the destination register address.
- INST_W, 32, width of the carried instruction word (debug and trace only).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  drop all held entries; synchronous.
- in_valid  in  1  EX presents a valid payload.
- in_ready  out  1  stage can accept; registered.
- ex_wd  in  REG_AW  destination register.
- ex_wreg  in  1  register write enable.
- ex_wdata  in  XLEN  ALU result or store data.
- ex_memaddr  in  XLEN  memory address.
- ex_memwr  in  1  0 = load, 1 = store.
- ex_memcnf  in  2  0 = no memory access, 1 = byte, 2 = halfword, 3 = word.
- ex_memsigned  in  1  sign-extend on load.
- ex_inst  in  INST_W  instruction word.
- out_valid  out  1  MEM payload valid.
- out_ready  in  1  MEM accepts this cycle.
- mem_wd, mem_wreg, mem_wdata, mem_memaddr, mem_memwr, mem_memcnf, mem_memsigned, mem_inst  out  widths as the ex_* ports  registered payload.

Behaviour:
- Storage: main entry M (drives the outputs) and skid entry S. Each holds a full payload plus a valid bit.
- States:
  - EMPTY: no entries held.
  - ONE: M valid.
  - TWO: M and S valid.
- in_ready is registered and equals (state != TWO).
- Transfer definitions: accept = in_valid & in_ready; drain = out_valid & out_ready.
- EMPTY:
  - accept -> ONE, payload written into M.
- ONE:
  - accept & drain -> ONE, M replaced by the new payload.
  - accept & !drain -> TWO, payload written into S.
  - !accept & drain -> EMPTY.
  - neither -> ONE, M held unchanged.
- TWO:
  - drain -> ONE, S moves to M.
  - no drain -> TWO, M and S held.
  - accept is impossible in TWO because in_ready = 0.
- out_valid = M valid.
- Bubble rule: when out_valid = 0, the outputs are forced to mem_wreg = 0, mem_memcnf = 0 and mem_wd = 0, so a bubble is a NOP at MEM. The other payload outputs keep their last value.
- Latency: an accepted payload appears on the outputs the next cycle.
- Throughput: one transfer per cycle when out_ready is held at 1.
- Ordering: strict FIFO. M is always older than S.
- Held payloads never change while not drained, even if ex_* inputs change.
- flush:
  - Next state is EMPTY and both valid bits clear.
  - Any accept in the same cycle is discarded.
  - A drain in the same cycle still completes; MEM owns that beat.
  - in_ready = 1 the following cycle.
- rst:
  - Same as flush, plus every payload register is cleared to 0.
  - Values after reset: out_valid = 0, in_ready = 1, all mem_* = 0.
  - Reset mid-transfer aborts both entries.
- rst has priority over flush; flush has priority over accept.
- No combinational path from out_ready to in_ready. The only input-to-output combinational paths are through the bubble forcing.

Optional Feature:
- Macro: EXMEM_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt, 32 bits.
  - Counts cycles with out_valid & !out_ready, saturating at 0xFFFFFFFF.
  - Cleared by rst only; flush does not clear it.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - memcnf encodings MEMCNF_NONE = 0, B = 1, H = 2, W = 3.
  - memwr encodings LOAD = 0, STORE = 1.
  - a packed typedef exmem_payload_t covering all eight fields.
  - the state enum {EMPTY, ONE, TWO}.
- One natural sub-module, skid_buf: a generic 2-entry skid buffer over a packed payload of width W. ex_mem_skid instantiates it and adds the bubble forcing and the optional counter.

Test Plan:
- Reset: hold rst 2 cycles with in_valid = 1 -> out_valid = 0, in_ready = 1, all mem_* = 0; no payload accepted.
- Streaming: out_ready = 1; send wdata 0x1, 0x2, 0x3 on consecutive cycles -> mem_wdata shows 0x1, 0x2, 0x3 one cycle later each, with no gaps.
- Backpressure: out_ready = 0; send A (wdata 0xA) then B (0xB) -> state TWO, in_ready = 0, mem_wdata = 0xA holds; raise out_ready -> 0xA, then 0xB, and in_ready returns to 1 one cycle after the first drain.
- Flush: with TWO entries held, assert flush together with in_valid (payload 0xC) -> next cycle out_valid = 0, mem_wreg = 0, mem_memcnf = 0; 0xC never appears.
- Bubble/NOP: an accepted store with memcnf = 3, memwr = 1, addr 0x100 drains, then in_valid = 0 -> following cycle out_valid = 0 and mem_memcnf = 0.
- Counter (EXMEM_STALL_CNT_EN): out_valid = 1 with out_ready = 0 for 5 cycles -> stall_cnt = 5; flush leaves stall_cnt = 5; rst -> 0.
